// File: rtl/dht11_pkg.sv
// rtl/dht11_pkg.sv - shared types and checksum helper for the DHT11 poll scheduler
package dht11_pkg;

    localparam int unsigned MS_W = 16;

    typedef enum logic [2:0] {
        WAIT,
        START,
        BUSY,
        CHECK,
        FAIL,
        RETRY_WAIT
    } sched_state_t;

    typedef struct packed {
        logic [7:0] hum_int;
        logic [7:0] hum_dec;
        logic [7:0] temp_int;
        logic [7:0] temp_dec;
        logic [7:0] chk;
    } dht11_frame_t;

    function automatic logic dht11_chk_ok(input dht11_frame_t f);
        logic [7:0] sum;
        sum = f.hum_int + f.hum_dec + f.temp_int + f.temp_dec;
        return (sum == f.chk);
    endfunction

endpackage

// File: rtl/dht11_ms_timer.sv
// rtl/dht11_ms_timer.sv - millisecond prescaler with a loadable down-counter and expiry flag
module dht11_ms_timer
    import dht11_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned INIT_MS = 2000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic [MS_W-1:0] load_val_i,
    output logic            expire_o
);

    localparam int unsigned DIV = CLK_HZ / 1000;

    logic            ms_tick;
    logic [MS_W-1:0] count_q;

    generate
        if (DIV <= 1) begin : g_no_prescale
            assign ms_tick = 1'b1;
        end else begin : g_prescale
            localparam int unsigned PW = $clog2(DIV);
            logic [PW-1:0] pre_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    pre_q <= '0;
                end else if (pre_q == PW'(DIV - 1)) begin
                    pre_q <= '0;
                end else begin
                    pre_q <= pre_q + PW'(1);
                end
            end
            assign ms_tick = (pre_q == PW'(DIV - 1));
        end
    endgenerate

    // Expiry fires on the tick that would take the count to zero, so a load of N
    // gives exactly N ticks before the owner sees expire_o.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= MS_W'(INIT_MS);
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (ms_tick && (count_q != '0)) begin
            count_q <= count_q - MS_W'(1);
        end
    end

    assign expire_o = ms_tick && (count_q <= MS_W'(1));

endmodule

// File: rtl/dht11_poll_scheduler.sv
// rtl/dht11_poll_scheduler.sv - DHT11 read sequencer: periodic/manual starts, timeout, checksum, latch
// Optional retry-with-backoff on failed reads is built when DHT11_RETRY_EN is defined.
module dht11_poll_scheduler
    import dht11_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned POLL_MS    = 2000,
    parameter int unsigned TIMEOUT_MS = 30,
    parameter int unsigned RETRY_MS   = 1100,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trig,
    output logic        rd_start,
    output logic        rd_abort,
    input  logic        rd_done,
    input  logic [39:0] rd_data,
    output logic [7:0]  hum_int,
    output logic [7:0]  temp_int,
    output logic        data_valid,
    output logic        err,
    output logic [15:0] sample_cnt
);

    sched_state_t    state_q, state_d;
    dht11_frame_t    frame_q, frame_d;
    logic [7:0]      hum_q, hum_d;
    logic [7:0]      temp_q, temp_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [15:0]     sample_cnt_q, sample_cnt_d;
    logic            tmr_load;
    logic [MS_W-1:0] tmr_val;
    logic            tmr_expire;

`ifdef DHT11_RETRY_EN
    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 2);
    logic [RTY_W-1:0] retry_q, retry_d;
`else
    logic unused_retry_cfg;
    assign unused_retry_cfg = (MAX_RETRY != 0) ^ (RETRY_MS != 0);
`endif

    // One timer serves the poll period, the read timeout and the retry back-off.
    dht11_ms_timer #(
        .CLK_HZ  (CLK_HZ),
        .INIT_MS (POLL_MS)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT;
            frame_q      <= '0;
            hum_q        <= '0;
            temp_q       <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            sample_cnt_q <= '0;
`ifdef DHT11_RETRY_EN
            retry_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            hum_q        <= hum_d;
            temp_q       <= temp_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            sample_cnt_q <= sample_cnt_d;
`ifdef DHT11_RETRY_EN
            retry_q      <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        hum_d        = hum_q;
        temp_d       = temp_q;
        valid_d      = valid_q;
        err_d        = err_q;
        sample_cnt_d = sample_cnt_q;
`ifdef DHT11_RETRY_EN
        retry_d      = retry_q;
`endif
        tmr_load     = 1'b0;
        tmr_val      = MS_W'(POLL_MS);
        rd_start     = 1'b0;
        rd_abort     = 1'b0;

        case (state_q)
            WAIT: begin
                if (tmr_expire || trig) begin
                    state_d = START;
                end
            end
            START: begin
                rd_start = !reset;
                tmr_load = 1'b1;
                tmr_val  = MS_W'(TIMEOUT_MS);
                state_d  = BUSY;
            end
            BUSY: begin
                // rd_done takes priority over a coincident timeout.
                if (rd_done) begin
                    frame_d = dht11_frame_t'(rd_data);
                    state_d = CHECK;
                end else if (tmr_expire) begin
                    rd_abort = !reset;
                    state_d  = FAIL;
                end
            end
            CHECK: begin
                if (dht11_chk_ok(frame_q)) begin
                    hum_d        = frame_q.hum_int;
                    temp_d       = frame_q.temp_int;
                    valid_d      = 1'b1;
                    err_d        = 1'b0;
                    sample_cnt_d = sample_cnt_q + 16'd1;
`ifdef DHT11_RETRY_EN
                    retry_d      = '0;
`endif
                    tmr_load     = 1'b1;
                    state_d      = WAIT;
                end else begin
                    state_d = FAIL;
                end
            end
            FAIL: begin
`ifdef DHT11_RETRY_EN
                if (retry_q < RTY_W'(MAX_RETRY)) begin
                    retry_d  = retry_q + RTY_W'(1);
                    tmr_load = 1'b1;
                    tmr_val  = MS_W'(RETRY_MS);
                    state_d  = RETRY_WAIT;
                end else begin
                    err_d    = 1'b1;
                    retry_d  = '0;
                    tmr_load = 1'b1;
                    state_d  = WAIT;
                end
`else
                err_d    = 1'b1;
                tmr_load = 1'b1;
                state_d  = WAIT;
`endif
            end
            RETRY_WAIT: begin
                if (tmr_expire) begin
                    state_d = START;
                end
            end
            default: begin
                state_d = WAIT;
            end
        endcase
    end

    assign hum_int    = hum_q;
    assign temp_int   = temp_q;
    assign data_valid = valid_q;
    assign err        = err_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_dht11_poll_scheduler.sv
// tb/tb_dht11_poll_scheduler.sv - directed self-checking bench for dht11_poll_scheduler
module tb_dht11_poll_scheduler;

    localparam int unsigned CLK_HZ     = 1000;
    localparam int unsigned POLL_MS    = 20;
    localparam int unsigned TIMEOUT_MS = 5;
    localparam int unsigned RETRY_MS   = 8;
    localparam int unsigned MAX_RETRY  = 2;

    localparam logic [39:0] GOOD_A = 40'h37_00_1A_00_51;
    localparam logic [39:0] BAD_A  = 40'h37_00_1A_00_52;
    localparam logic [39:0] GOOD_B = 40'h41_00_17_00_58;

    logic        clk = 1'b0;
    logic        reset;
    logic        trig;
    logic        rd_start;
    logic        rd_abort;
    logic        rd_done;
    logic [39:0] rd_data;
    logic [7:0]  hum_int;
    logic [7:0]  temp_int;
    logic        data_valid;
    logic        err;
    logic [15:0] sample_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dht11_poll_scheduler #(
        .CLK_HZ     (CLK_HZ),
        .POLL_MS    (POLL_MS),
        .TIMEOUT_MS (TIMEOUT_MS),
        .RETRY_MS   (RETRY_MS),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .trig       (trig),
        .rd_start   (rd_start),
        .rd_abort   (rd_abort),
        .rd_done    (rd_done),
        .rd_data    (rd_data),
        .hum_int    (hum_int),
        .temp_int   (temp_int),
        .data_valid (data_valid),
        .err        (err),
        .sample_cnt (sample_cnt)
    );

    task automatic wait_rd_start(input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (rd_start) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic wait_rd_abort(input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (rd_abort) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        trig    = 1'b0;
        rd_done = 1'b0;
        rd_data = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({rd_start, rd_abort, hum_int, temp_int, data_valid, err, sample_cnt} !== 36'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {rd_start, rd_abort, hum_int, temp_int, data_valid, err, sample_cnt});
        end
        reset = 1'b0;
    endtask

    task automatic test_first_read();
        int c;
        wait_rd_start(30, c);
        n_cmp++;
        if (c !== 20) begin
            n_bad++;
            $display("FAIL first_start_cycle: got %0d want 20", c);
        end
        @(negedge clk);
        @(negedge clk);
        rd_done = 1'b1;
        rd_data = GOOD_A;
        @(negedge clk);
        rd_done = 1'b0;
        n_cmp++;
        if ({data_valid, sample_cnt} !== 17'd0) begin
            n_bad++;
            $display("FAIL early_update: got valid=%0d cnt=%0d want 0/0", data_valid, sample_cnt);
        end
        @(negedge clk);
        n_cmp++;
        if ({hum_int, temp_int, data_valid, err, sample_cnt} !== {8'h37, 8'h1A, 1'b1, 1'b0, 16'd1}) begin
            n_bad++;
            $display("FAIL good_read_a: got hum=%h temp=%h valid=%0d err=%0d cnt=%0d want 37/1a/1/0/1",
                     hum_int, temp_int, data_valid, err, sample_cnt);
        end
    endtask

    task automatic test_bad_checksum();
        int c;
        wait_rd_start(25, c);
        n_cmp++;
        if (c !== 20) begin
            n_bad++;
            $display("FAIL poll_period: got %0d want 20", c);
        end
        @(negedge clk);
        rd_done = 1'b1;
        rd_data = BAD_A;
        @(negedge clk);
        rd_done = 1'b0;
`ifdef DHT11_RETRY_EN
        for (int r = 0; r < int'(MAX_RETRY); r++) begin
            wait_rd_start(15, c);
            n_cmp++;
            if (c !== 10 || err !== 1'b0) begin
                n_bad++;
                $display("FAIL chk_retry_spacing: got %0d err=%0d want 10 err=0", c, err);
            end
            @(negedge clk);
            rd_done = 1'b1;
            rd_data = BAD_A;
            @(negedge clk);
            rd_done = 1'b0;
        end
`endif
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL chk_err: got %0d want 1", err);
        end
        n_cmp++;
        if ({hum_int, temp_int, data_valid, sample_cnt} !== {8'h37, 8'h1A, 1'b1, 16'd1}) begin
            n_bad++;
            $display("FAIL chk_keeps_data: got hum=%h temp=%h valid=%0d cnt=%0d want 37/1a/1/1",
                     hum_int, temp_int, data_valid, sample_cnt);
        end
    endtask

    task automatic test_trig();
        int starts;
        repeat (7) @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        n_cmp++;
        if (rd_start !== 1'b1) begin
            n_bad++;
            $display("FAIL trig_start: got %0d want 1", rd_start);
        end
        @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig    = 1'b0;
        rd_done = 1'b1;
        rd_data = GOOD_B;
        @(negedge clk);
        rd_done = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({hum_int, temp_int, err, sample_cnt} !== {8'h41, 8'h17, 1'b0, 16'd2}) begin
            n_bad++;
            $display("FAIL good_read_b: got hum=%h temp=%h err=%0d cnt=%0d want 41/17/0/2",
                     hum_int, temp_int, err, sample_cnt);
        end
        starts = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rd_start) starts++;
        end
        n_cmp++;
        if (starts !== 0) begin
            n_bad++;
            $display("FAIL trig_busy_ignored: got %0d starts want 0", starts);
        end
    endtask

    task automatic test_timeout();
        int c;
        wait_rd_start(10, c);
        n_cmp++;
        if (c !== 5) begin
            n_bad++;
            $display("FAIL timeout_start: got %0d want 5", c);
        end
        wait_rd_abort(10, c);
        n_cmp++;
        if (c !== 5) begin
            n_bad++;
            $display("FAIL abort_delay: got %0d want 5", c);
        end
`ifdef DHT11_RETRY_EN
        for (int r = 0; r < int'(MAX_RETRY); r++) begin
            wait_rd_start(15, c);
            n_cmp++;
            if (c !== 10) begin
                n_bad++;
                $display("FAIL to_retry_spacing: got %0d want 10", c);
            end
            wait_rd_abort(10, c);
            n_cmp++;
            if (c !== 5) begin
                n_bad++;
                $display("FAIL to_retry_abort: got %0d want 5", c);
            end
        end
`endif
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_before_fail: got %0d want 0", err);
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_err: got %0d want 1", err);
        end
    endtask

    task automatic test_wrap_and_race();
        int c;
        force dut.sample_cnt_q = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        release dut.sample_cnt_q;
        wait_rd_start(25, c);
        n_cmp++;
        if (c !== 18) begin
            n_bad++;
            $display("FAIL wrap_start: got %0d want 18", c);
        end
        repeat (5) @(negedge clk);
        rd_done = 1'b1;
        rd_data = GOOD_A;
        #1;
        n_cmp++;
        if (rd_abort !== 1'b0) begin
            n_bad++;
            $display("FAIL race_abort: got %0d want 0", rd_abort);
        end
        @(negedge clk);
        rd_done = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({hum_int, temp_int, data_valid, err, sample_cnt} !== {8'h37, 8'h1A, 1'b1, 1'b0, 16'd0}) begin
            n_bad++;
            $display("FAIL wrap_race: got hum=%h temp=%h valid=%0d err=%0d cnt=%h want 37/1a/1/0/0000",
                     hum_int, temp_int, data_valid, err, sample_cnt);
        end
    endtask

    task automatic test_reset_in_busy();
        int c;
        wait_rd_start(25, c);
        n_cmp++;
        if (c !== 20) begin
            n_bad++;
            $display("FAIL busy_start: got %0d want 20", c);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({rd_start, rd_abort, hum_int, temp_int, data_valid, err, sample_cnt} !== 36'd0) begin
            n_bad++;
            $display("FAIL busy_reset_outputs: got %h want 0",
                     {rd_start, rd_abort, hum_int, temp_int, data_valid, err, sample_cnt});
        end
        reset = 1'b0;
        wait_rd_start(30, c);
        n_cmp++;
        if (c !== 20) begin
            n_bad++;
            $display("FAIL post_reset_start: got %0d want 20", c);
        end
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_bad_checksum();
        test_trig();
        test_timeout();
        test_wrap_and_race();
        test_reset_in_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
